// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
//   state_t   : responder FSM states (IDLE/BUSY/RESP)
//   HI_LANE / LO_LANE : value of addr[1] selecting word bits [31:16] / [15:0]
//   addr_err  : request error check (range + alignment)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic HI_LANE = 1'b0;
  localparam logic LO_LANE = 1'b1;

  // Word index out of range, or misaligned for the access size.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic        half,
                                    input int unsigned depth);
    logic bad_idx;
    bad_idx = (32'(addr[31:2]) >= depth);
    if (half) return bad_idx | addr[0];
    else      return bad_idx | (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous-write, combinational-read storage of DEPTH_WORDS x 32 bits,
// with independent write enables for the upper and lower 16-bit halves.
// Ports:
//   clk    in   clock
//   we_hi  in   write wdata[31:16] into word idx
//   we_lo  in   write wdata[15:0]  into word idx
//   idx    in   word index (read and write)
//   wdata  in   write data
//   rdata  out  word at idx (combinational)
// Contents are not reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          we_hi,
  input  logic          we_lo,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_hi) mem[idx][31:16] <= wdata[31:16];
    if (we_lo) mem[idx][15:0]  <= wdata[15:0];
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one load/store per handshake,
// holds it WAIT_CYCLES cycles, performs the access, then pulses rsp_valid
// for one cycle with read data or an error.
// Optional feature: define DMEM_HALF_EN for big-endian halfword accesses;
// without it every access is a word access and req_half/req_unsigned are
// ignored.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_ready request handshake
//   req_we              1 = store
//   req_addr            byte address
//   req_wdata           store data (halfword store uses [15:0])
//   req_half            halfword access
//   req_unsigned        zero-extend halfword load
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           load data (0 for stores and errors)
//   rsp_err             request rejected
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_half,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        c_we, c_half, c_uns;
  logic [31:0] c_addr, c_wdata;

  logic        accept, access;
  logic        a_we, a_half, a_uns;
  logic [31:0] a_addr, a_wdata;
  logic        err;
  logic        we_hi, we_lo;
  logic [31:0] mem_wdata, rd_word, load_val;

  assign accept = (state == IDLE) && req_valid;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request fields are used in IDLE and the captured copy otherwise.
  assign a_we    = (state == IDLE) ? req_we    : c_we;
  assign a_addr  = (state == IDLE) ? req_addr  : c_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : c_wdata;

  assign access = (accept && (WAIT_CYCLES == 0)) ||
                  ((state == BUSY) && (cnt == 4'd1));

`ifdef DMEM_HALF_EN
  logic [15:0] half_sel;

  assign a_half = (state == IDLE) ? req_half     : c_half;
  assign a_uns  = (state == IDLE) ? req_unsigned : c_uns;
  assign err    = addr_err(a_addr, a_half, DEPTH_WORDS);

  assign we_hi = access && a_we && !err && (!a_half || (a_addr[1] == HI_LANE));
  assign we_lo = access && a_we && !err && (!a_half || (a_addr[1] == LO_LANE));
  assign mem_wdata = a_half ? {a_wdata[15:0], a_wdata[15:0]} : a_wdata;

  assign half_sel = (a_addr[1] == HI_LANE) ? rd_word[31:16] : rd_word[15:0];
  assign load_val = !a_half ? rd_word :
                    a_uns   ? {16'h0000, half_sel} :
                              {{16{half_sel[15]}}, half_sel};
`else
  logic unused_half;

  assign a_half      = 1'b0;
  assign a_uns       = 1'b0;
  assign unused_half = ^{c_half, c_uns, a_half, a_uns};
  assign err         = addr_err(a_addr, 1'b0, DEPTH_WORDS);
  assign we_hi       = access && a_we && !err;
  assign we_lo       = we_hi;
  assign mem_wdata   = a_wdata;
  assign load_val    = rd_word;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we_hi(we_hi),
    .we_lo(we_lo),
    .idx  (a_addr[AW+1:2]),
    .wdata(mem_wdata),
    .rdata(rd_word)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY: if (cnt == 4'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      c_we      <= 1'b0;
      c_half    <= 1'b0;
      c_uns     <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        c_we    <= req_we;
        c_half  <= req_half;
        c_uns   <= req_unsigned;
        c_addr  <= req_addr;
        c_wdata <= req_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_rdata <= (a_we || err) ? '0 : load_val;
        rsp_err   <= err;
      end else if (state == RESP) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned WAIT = 2;
`ifdef DMEM_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_half = 1'b0, req_unsigned = 1'b0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_valid = 1'b0, z_ready, z_we = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic        z_rsp_valid, z_err;
  logic [31:0] z_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] model [int];
  rsp_t        sb [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_half(req_half),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
    .req_addr(z_addr), .req_wdata(z_wdata), .req_half(1'b0),
    .req_unsigned(1'b0),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: big-endian halfwords, range/alignment errors.
  function automatic rsp_t model_access(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic half,
                                        input logic uns);
    logic        hf, bad;
    int          idx;
    logic [31:0] w;
    logic [15:0] h;
    hf  = HALF && half;
    idx = int'(addr[31:2]);
    bad = (addr[31:2] >= 30'd256) || (hf ? addr[0] : (addr[1:0] != 2'b00));
    if (bad) return '{rdata: 32'h0, err: 1'b1};
    w = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
    if (we) begin
      if (!hf)           w = wdata;
      else if (!addr[1]) w[31:16] = wdata[15:0];
      else               w[15:0]  = wdata[15:0];
      model[idx] = w;
      return '{rdata: 32'h0, err: 1'b0};
    end
    if (!hf) return '{rdata: w, err: 1'b0};
    h = addr[1] ? w[15:0] : w[31:16];
    return '{rdata: uns ? {16'h0000, h} : {{16{h[15]}}, h}, err: 1'b0};
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic half, input logic uns);
    int   n;
    bit   got;
    rsp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_half = half; req_unsigned = uns;
    sb.push_back(model_access(we, addr, wdata, half, uns));
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) check_eq("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Junk on the request port while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = $urandom & 32'h0000_03FC; req_wdata = $urandom;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      check_eq("ready_busy", {31'b0, req_ready}, 32'd0);
      if (rsp_valid) got = 1;
    end
    req_valid = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check_eq("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    end else begin
      check_eq("latency", n, WAIT + 1);
      check_eq($sformatf("rdata@%h", addr), rsp_rdata, e.rdata);
      check_eq($sformatf("err@%h", addr), {31'b0, rsp_err}, {31'b0, e.err});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_err"},   {31'b0, rsp_err},   32'd0);
  endtask

  initial begin
    int last_k;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    do_req(1, 32'h00, 32'h0BAD_F00D, 0, 0);
    do_req(1, 32'h10, 32'h1234_5678, 0, 0);
    do_req(0, 32'h10, 32'h0,         0, 0);
    do_req(1, 32'h12, 32'h0000_BEEF, 1, 0);
    do_req(0, 32'h10, 32'h0,         0, 0);
    do_req(0, 32'h12, 32'h0,         1, 0);
    do_req(0, 32'h12, 32'h0,         1, 1);
    do_req(0, 32'h10, 32'h0,         1, 0);
    do_req(0, 32'h11, 32'h0,         0, 0);
    do_req(0, 32'h400, 32'h0,        0, 0);
    do_req(1, 32'h400, 32'hDEAD_BEEF, 0, 0);
    do_req(0, 32'h00, 32'h0,         0, 0);
    do_req(0, 32'h13, 32'h0,         1, 0);
    do_req(1, 32'h30, 32'h1111_2222, 0, 0);
    do_req(1, 32'h30, 32'hCAFE_F00D, 1, 0);
    do_req(0, 32'h30, 32'h0,         0, 0);
    do_req(0, 32'h30, 32'h0,         1, 1);

    // Reset in the middle of a store's wait states.
    do_req(1, 32'h20, 32'hAAAA_0000, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555;
    req_half = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_outputs("rst_busy");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
    do_req(0, 32'h20, 32'h0, 0, 0);

    // Zero-wait instance with req_valid held high: one accept every 2 cycles.
    last_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("z_ready%0d", k), {31'b0, z_ready}, {31'b0, (k % 2 == 0)});
      check_eq($sformatf("z_rsp%0d", k), {31'b0, z_rsp_valid}, {31'b0, (k % 2 == 1)});
      if (k % 2 == 1) check_eq("z_store_rdata", z_rdata, 32'd0);
      if (z_ready) last_k = k;
      z_valid = 1'b1; z_we = 1'b1; z_addr = 32'(4 * k); z_wdata = 32'hC0DE_0000 + 32'(k);
    end
    @(negedge clk) z_valid = 1'b0;
    @(negedge clk);
    z_valid = 1'b1; z_we = 1'b0; z_addr = 32'(4 * last_k);
    @(posedge clk); #1 z_valid = 1'b0;
    @(negedge clk);
    check_eq("z_load_valid", {31'b0, z_rsp_valid}, 32'd1);
    check_eq("z_load_rdata", z_rdata, 32'hC0DE_0000 + 32'(last_k));
    check_eq("z_load_err", {31'b0, z_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
